// File: rtl/instr_queue_if.sv
// Handshake bundle between the fetch stage, the instruction queue and decode.
// The queue connects through the slave modport; the fetch/decode side
// (or a testbench standing in for it) uses the master modport.
interface instr_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            flush_i;
  logic            enq_valid_i;
  logic            enq_ready_o;
  logic [XLEN-1:0] enq_pc_i;
  logic [XLEN-1:0] enq_instr_i;
  logic            deq_valid_o;
  logic            deq_ready_i;
  logic [XLEN-1:0] deq_pc_o;
  logic [XLEN-1:0] deq_instr_o;
  logic [CW-1:0]   count_o;

  modport slave (
    input  flush_i, enq_valid_i, enq_pc_i, enq_instr_i, deq_ready_i,
    output enq_ready_o, deq_valid_o, deq_pc_o, deq_instr_o, count_o
  );

  modport master (
    output flush_i, enq_valid_i, enq_pc_i, enq_instr_i, deq_ready_i,
    input  enq_ready_o, deq_valid_o, deq_pc_o, deq_instr_o, count_o
  );
endinterface

// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode: a circular FIFO of {PC, instr}
// pairs with wrap-bit pointers, branch-redirect flush and occupancy count.
// Optional macro INSTR_QUEUE_BYPASS_EN lets an instruction presented to an
// empty queue appear on the dequeue side in the same cycle; without it the
// enqueue-to-dequeue latency is one clock and no combinational path exists.
module instr_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic clk,
  input  logic reset,
  instr_queue_if.slave q_if
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;
  logic            full;
  logic            empty;
  logic            do_enq;
  logic            do_deq;
  logic            bypass_take;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);

  assign q_if.enq_ready_o = !full;
  assign q_if.count_o     = wr_ptr - rd_ptr;

`ifdef INSTR_QUEUE_BYPASS_EN
  logic bypass_active;
  assign bypass_active = empty && q_if.enq_valid_i && !q_if.flush_i;
  assign bypass_take   = bypass_active && q_if.deq_ready_i;

  // Head entry when occupied, otherwise forward the fetch inputs straight through
  always_comb begin
    q_if.deq_valid_o = 1'b0;
    q_if.deq_pc_o    = '0;
    q_if.deq_instr_o = '0;
    if (!empty) begin
      q_if.deq_valid_o = 1'b1;
      q_if.deq_pc_o    = pc_mem[rd_idx];
      q_if.deq_instr_o = instr_mem[rd_idx];
    end else if (bypass_active) begin
      q_if.deq_valid_o = 1'b1;
      q_if.deq_pc_o    = q_if.enq_pc_i;
      q_if.deq_instr_o = q_if.enq_instr_i;
    end
  end
`else
  assign bypass_take = 1'b0;

  // Head entry straight from storage; zeros while empty
  always_comb begin
    q_if.deq_valid_o = 1'b0;
    q_if.deq_pc_o    = '0;
    q_if.deq_instr_o = '0;
    if (!empty) begin
      q_if.deq_valid_o = 1'b1;
      q_if.deq_pc_o    = pc_mem[rd_idx];
      q_if.deq_instr_o = instr_mem[rd_idx];
    end
  end
`endif

  // A bypassed instruction is consumed in flight and never occupies a slot
  assign do_enq = q_if.enq_valid_i && !full && !q_if.flush_i && !bypass_take;
  assign do_deq = !empty && q_if.deq_ready_i && !q_if.flush_i;

  // Pointer update; flush redirects both pointers home and drops this cycle's traffic
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (q_if.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_deq) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents are don't-care while the slot is unoccupied
  always_ff @(posedge clk) begin
    if (do_enq) begin
      pc_mem[wr_idx]    <= q_if.enq_pc_i;
      instr_mem[wr_idx] <= q_if.enq_instr_i;
    end
  end
endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue (DEPTH=8, XLEN=32): a vector table for
// fill/full/drain, directed multi-cycle sequences, and a random phase checked
// against a queue-based reference model. Honours INSTR_QUEUE_BYPASS_EN.
module tb_instr_queue;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef struct {
    logic        enq_valid;
    logic [31:0] enq_pc;
    logic        deq_ready;
    logic [3:0]  exp_count;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_ready;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   next_pc;
  entry_t model_q[$];
  vec_t   vecs[17];

  instr_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) q_if ();

  instr_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .q_if  (q_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(logic [31:0] pc);
    return pc ^ 32'h1300_0013;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle, compare pre-edge outputs with the model, clock, update the model
  task automatic applyStimulus(logic fl, logic ev, logic [31:0] pc, logic dr);
    logic        e_valid;
    logic        e_ready;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        bypassed;
    entry_t      ent;
    q_if.flush_i     = fl;
    q_if.enq_valid_i = ev;
    q_if.enq_pc_i    = pc;
    q_if.enq_instr_i = instr_of(pc);
    q_if.deq_ready_i = dr;
    #1;
    e_ready = (model_q.size() < DEPTH);
    e_valid = 1'b0;
    e_pc    = 32'h0;
    e_instr = 32'h0;
    if (model_q.size() > 0) begin
      e_valid = 1'b1;
      e_pc    = model_q[0].pc;
      e_instr = model_q[0].instr;
    end
`ifdef INSTR_QUEUE_BYPASS_EN
    else if (ev && !fl) begin
      e_valid = 1'b1;
      e_pc    = pc;
      e_instr = instr_of(pc);
    end
`endif
    checkOutput("deq_valid", {31'b0, q_if.deq_valid_o}, {31'b0, e_valid});
    checkOutput("deq_pc", q_if.deq_pc_o, e_pc);
    checkOutput("deq_instr", q_if.deq_instr_o, e_instr);
    checkOutput("enq_ready", {31'b0, q_if.enq_ready_o}, {31'b0, e_ready});
    checkOutput("count", {28'b0, q_if.count_o}, model_q.size());
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      bypassed = 1'b0;
      if (e_valid && dr) begin
        if (model_q.size() > 0) void'(model_q.pop_front());
        else bypassed = 1'b1;
      end
      if (ev && e_ready && !bypassed) begin
        ent.pc    = pc;
        ent.instr = instr_of(pc);
        model_q.push_back(ent);
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    q_if.flush_i     = 1'b0;
    q_if.enq_valid_i = 1'b0;
    q_if.enq_pc_i    = 32'h0;
    q_if.enq_instr_i = 32'h0;
    q_if.deq_ready_i = 1'b0;
  endtask

  task automatic check_reset_outputs(string tag);
    checkOutput({tag, "_count"}, {28'b0, q_if.count_o}, 32'd0);
    checkOutput({tag, "_deq_valid"}, {31'b0, q_if.deq_valid_o}, 32'd0);
    checkOutput({tag, "_deq_pc"}, q_if.deq_pc_o, 32'd0);
    checkOutput({tag, "_deq_instr"}, q_if.deq_instr_o, 32'd0);
    checkOutput({tag, "_enq_ready"}, {31'b0, q_if.enq_ready_o}, 32'd1);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    next_pc = 32'h1000;
    reset   = 1'b0;
    idle_inputs();

    // Fill eight, offer a ninth while full, then drain in order
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 32'(4 * i), 1'b0, 4'(i + 1), 1'b1, 32'h0, (i + 1 < DEPTH)};
    vecs[8] = '{1'b1, 32'h20, 1'b0, 4'd8, 1'b1, 32'h0, 1'b0};
    for (int k = 0; k < 8; k++)
      vecs[9 + k] = '{1'b0, 32'h0, 1'b1, 4'(7 - k), (k < 7),
                      (k < 7) ? 32'(4 * (k + 1)) : 32'h0, 1'b1};

    #12;
    check_reset_outputs("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) begin
      q_if.enq_valid_i = vecs[i].enq_valid;
      q_if.enq_pc_i    = vecs[i].enq_pc;
      q_if.enq_instr_i = instr_of(vecs[i].enq_pc);
      q_if.deq_ready_i = vecs[i].deq_ready;
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_count", i), {28'b0, q_if.count_o}, {28'b0, vecs[i].exp_count});
      checkOutput($sformatf("vec%0d_deq_valid", i), {31'b0, q_if.deq_valid_o}, {31'b0, vecs[i].exp_valid});
      checkOutput($sformatf("vec%0d_deq_pc", i), q_if.deq_pc_o, vecs[i].exp_pc);
      checkOutput($sformatf("vec%0d_deq_instr", i), q_if.deq_instr_o,
                  vecs[i].exp_valid ? instr_of(vecs[i].exp_pc) : 32'h0);
      checkOutput($sformatf("vec%0d_enq_ready", i), {31'b0, q_if.enq_ready_o}, {31'b0, vecs[i].exp_ready});
    end
    idle_inputs();

    // Continuous enqueue+dequeue across pointer wrap
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 32'(4 * i), 1'b1);
    while (model_q.size() > 0) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    // Full with dequeue requested: offered entry refused, space appears next cycle
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 32'h200 + 32'(4 * i), 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h2FC, 1'b1);
    checkOutput("full_deq_count", {28'b0, q_if.count_o}, 32'd7);
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b0);
    while (model_q.size() > 0) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    // Flush beats a concurrent enqueue
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 32'h400 + 32'(4 * i), 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h999, 1'b1);
    checkOutput("flush_count", {28'b0, q_if.count_o}, 32'd0);
    checkOutput("flush_deq_valid", {31'b0, q_if.deq_valid_o}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

    // Reset asserted between edges clears outputs with no clock
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 32'h500 + 32'(4 * i), 1'b0);
    idle_inputs();
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    reset = 1'b1;
    model_q.delete();
    @(posedge clk);
    #1;

    // Empty queue, instruction offered with decode ready
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1);
`ifdef INSTR_QUEUE_BYPASS_EN
    checkOutput("bypass_count", {28'b0, q_if.count_o}, 32'd0);
    checkOutput("bypass_deq_valid_after", {31'b0, q_if.deq_valid_o}, 32'd0);
`else
    checkOutput("latency_deq_valid", {31'b0, q_if.deq_valid_o}, 32'd1);
    checkOutput("latency_deq_pc", q_if.deq_pc_o, 32'h100);
`endif
    while (model_q.size() > 0) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    // Random traffic, first biased toward filling, then toward draining
    for (int i = 0; i < 400; i++) begin
      logic fl;
      logic ev;
      logic dr;
      fl = ($urandom_range(0, 39) == 0);
      ev = ($urandom_range(0, 3) != 0);
      dr = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      applyStimulus(fl, ev, 32'(next_pc), dr);
      next_pc += 4;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
